// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive front end with 16x oversampling.
// Synchronises rx_in and recovers 8N1 frames, or 8E1 frames when
// UART_RX_PARITY_EN is defined. Each byte is held behind a ready/ack handshake.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   rx_in     - raw asynchronous serial line, idle high
//   rd_ack    - one-cycle pulse that consumes the held byte and clears the flags
//   rx_data   - last accepted byte (LSB first on the wire)
//   rx_ready  - rx_data holds an unconsumed byte
//   frame_err - sticky: bad stop bit or bad parity
//   overrun   - sticky: a byte was dropped because the previous one was unread
//   busy      - receiver FSM not idle
module uart_rx_deframer #(
    parameter int unsigned BAUD_DIV   = 325,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(9);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t              state, state_d;
    logic                rx_meta, rx_s, rx_prev;
    logic [1:0]          hist;
    logic [BAUD_W-1:0]   baud_cnt, baud_cnt_d;
    logic [SCNT_W-1:0]   scnt, scnt_d;
    logic [2:0]          bit_idx, bit_idx_d;
    logic [7:0]          shreg, shreg_d;
    logic                brk_high, brk_high_d;
    logic [7:0]          rx_data_d;
    logic                rx_ready_d, frame_err_d, overrun_d, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                par_bad, par_bad_d;
`endif

    logic tick, maj, at_mid, at_end, done, set_ferr;

    assign tick   = (baud_cnt == BAUD_LAST);
    // hist holds the samples from counts 7 and 8; rx_s is the count-9 sample
    assign maj    = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
    assign at_mid = tick && (scnt == SCNT_MID);
    assign at_end = tick && (scnt == SCNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            hist      <= 2'b11;
            baud_cnt  <= '0;
            scnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            brk_high  <= 1'b0;
            rx_data   <= 8'h00;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            rx_meta   <= rx_in;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            if (tick) hist <= {hist[0], rx_s};
            baud_cnt  <= baud_cnt_d;
            scnt      <= scnt_d;
            bit_idx   <= bit_idx_d;
            shreg     <= shreg_d;
            brk_high  <= brk_high_d;
            rx_data   <= rx_data_d;
            rx_ready  <= rx_ready_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
            busy      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_d;
`endif
        end
    end

    // Next-state, frame sequencing and handshake logic
    always_comb begin
        state_d     = state;
        baud_cnt_d  = tick ? '0 : baud_cnt + BAUD_W'(1);
        scnt_d      = tick ? scnt + SCNT_W'(1) : scnt;
        bit_idx_d   = bit_idx;
        shreg_d     = shreg;
        brk_high_d  = brk_high;
        done        = 1'b0;
        set_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad;
`endif

        case (state)
            S_IDLE: begin
                // Realign bit timing to the falling edge of the start bit
                if (rx_prev && !rx_s) begin
                    state_d    = S_START;
                    scnt_d     = '0;
                    baud_cnt_d = '0;
                end
            end
            S_START: begin
                if (at_mid && maj) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (at_mid) shreg_d[bit_idx] = maj;
                if (at_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (at_mid) par_bad_d = (^shreg) ^ maj;
                if (at_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave at mid-bit so a back-to-back start edge is not missed
                if (at_mid) begin
                    if (maj) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) set_ferr = 1'b1;
                        else         done     = 1'b1;
`else
                        done = 1'b1;
`endif
                    end else begin
                        set_ferr   = 1'b1;
                        state_d    = S_BREAK;
                        brk_high_d = 1'b0;
                    end
                end
            end
            S_BREAK: begin
                // Require the line high across one whole tick interval
                if (!rx_s) begin
                    brk_high_d = 1'b0;
                end else if (tick) begin
                    if (brk_high) state_d = S_IDLE;
                    else          brk_high_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_data_d   = rx_data;
        rx_ready_d  = rx_ready;
        frame_err_d = frame_err;
        overrun_d   = overrun;
        if (rd_ack) begin
            rx_ready_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        // A simultaneous ack frees the holding register for the new byte
        if (done) begin
            if (!rx_ready || rd_ack) begin
                rx_data_d  = shreg;
                rx_ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (set_ferr) frame_err_d = 1'b1;
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer with BAUD_DIV=4 (64 clk per bit).
// Expected bytes go into a queue as frames are sent; a monitor pops and
// compares whenever the DUT presents a new byte.
module tb_uart_rx_deframer;

    localparam int unsigned BAUD_DIV = 4;
    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Negedges from the start-bit falling edge to the cycle of the stop-bit
    // count-9 tick: 2 sync + 1 detect + 3 to first tick, then 4 clk per tick.
    localparam int DONE_DLY = 6 + 4 * (16 * (NBITS - 1) + 9);

    logic       clk = 1'b0;
    logic       reset, rx_in, rd_ack;
    logic [7:0] rx_data;
    logic       rx_ready, frame_err, overrun, busy;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       prev_ready = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clk = ~clk;

    uart_rx_deframer #(.BAUD_DIV(BAUD_DIV), .OVERSAMPLE(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rd_ack   (rd_ack),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    // Sends one frame; the line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip, input logic ack_done);
        logic        par;
        logic [10:0] fr;
        par = (^d) ^ par_flip;
`ifdef UART_RX_PARITY_EN
        fr = {stop, par, d, 1'b0};
`else
        fr = {par, stop, d, 1'b0};  // bit 10 is never driven in 8N1
`endif
        @(negedge clk);
        fork
            begin
                for (int b = 0; b < NBITS; b++) begin
                    rx_in = fr[b];
                    repeat (BIT_CLKS) @(negedge clk);
                end
            end
            begin
                if (ack_done) begin
                    repeat (DONE_DLY) @(negedge clk);
                    rd_ack = 1'b1;
                    @(negedge clk);
                    rd_ack = 1'b0;
                end
            end
        join
    endtask

    // Monitor: a new byte is a rise of rx_ready or a data change while ready
    always @(negedge clk) begin
        if (!reset && rx_ready && (!prev_ready || rx_data != prev_data)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h expected none", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(mon_exp));
                if (!prev_ready) begin
                    check("busy_at_ready", 32'(busy), 0);
                    check("busy_before_ready", 32'(prev_busy), 1);
                end
            end
        end
        prev_ready = rx_ready;
        prev_busy  = busy;
        prev_data  = rx_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        rx_in  = 1'b1;
        rd_ack = 1'b0;
        idle(5);
        reset = 1'b0;
        idle(5);
        check("rst_data", 32'(rx_data), 0);
        check("rst_ready", 32'(rx_ready), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);

        // Single byte
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check("t1_ready", 32'(rx_ready), 1);
        check("t1_ferr", 32'(frame_err), 0);
        check("t1_busy", 32'(busy), 0);
        pulse_ack();
        check("t1_ack_ready", 32'(rx_ready), 0);
        check("t1_ack_data", 32'(rx_data), 32'h55);

        // Overrun: second byte dropped
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        check("t2_data", 32'(rx_data), 32'hA3);
        check("t2_ready", 32'(rx_ready), 1);
        check("t2_ovr", 32'(overrun), 1);
        pulse_ack();
        check("t2_ack_ready", 32'(rx_ready), 0);
        check("t2_ack_ovr", 32'(overrun), 0);
        check("t2_ack_data", 32'(rx_data), 32'hA3);

        // Ack coincident with delivery of the next byte
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(10);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        check("t3_data", 32'(rx_data), 32'hC3);
        check("t3_ready", 32'(rx_ready), 1);
        check("t3_ovr", 32'(overrun), 0);
        pulse_ack();

        // Bad stop bit held low for 3 bit times, then recovery
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check("t4_ferr", 32'(frame_err), 1);
        check("t4_ready", 32'(rx_ready), 0);
        check("t4_busy_break", 32'(busy), 1);
        idle(2 * BIT_CLKS);
        check("t4_busy_hold", 32'(busy), 1);
        rx_in = 1'b1;
        idle(BIT_CLKS);
        check("t4_busy_idle", 32'(busy), 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        check("t4_data", 32'(rx_data), 32'h7E);
        check("t4_ferr_sticky", 32'(frame_err), 1);
        pulse_ack();
        check("t4_ack_ferr", 32'(frame_err), 0);
        check("t4_ack_ready", 32'(rx_ready), 0);

        // 20-clk glitch on an idle line
        @(negedge clk);
        rx_in = 1'b0;
        idle(20);
        rx_in = 1'b1;
        idle(10);
        check("t5_glitch_busy", 32'(busy), 1);
        idle(70);
        check("t5_glitch_idle", 32'(busy), 0);
        check("t5_glitch_ready", 32'(rx_ready), 0);
        check("t5_glitch_ferr", 32'(frame_err), 0);
        check("t5_glitch_ovr", 32'(overrun), 0);

        // Reset in the middle of the data bits of 0xFF
        @(negedge clk);
        rx_in = 1'b0;
        idle(BIT_CLKS);
        rx_in = 1'b1;
        idle(150);
        check("t5_mid_busy", 32'(busy), 1);
        reset = 1'b1;
        idle(3);
        check("t5_rst_data", 32'(rx_data), 0);
        check("t5_rst_ready", 32'(rx_ready), 0);
        check("t5_rst_ferr", 32'(frame_err), 0);
        check("t5_rst_ovr", 32'(overrun), 0);
        check("t5_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        idle(BIT_CLKS);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        check("t5_data", 32'(rx_data), 32'h12);
        check("t5_ready", 32'(rx_ready), 1);
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity needs a 1
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check("t6_ready", 32'(rx_ready), 1);
        check("t6_ferr", 32'(frame_err), 0);
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("t6_bad_ferr", 32'(frame_err), 1);
        check("t6_bad_ready", 32'(rx_ready), 0);
        check("t6_bad_busy", 32'(busy), 0);
        pulse_ack();
`endif

        idle(20);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
